seq_multiplier: RTL and testbench

- Parametrised, iterative shift-add multiplier. It is the successor of the fixed 3-bit times-table multiplier.
- Accepts one operand pair through a valid/ready handshake and computes one multiplier bit per clock.
- Presents the 2*WIDTH-bit product through a valid/ready output handshake.
- Supports unsigned and two's-complement operands, selected per operation. Sits between an operand source and a result consumer in the arithmetic exercises.

---
 rtl/mult_pkg.sv | 23 ++
 rtl/mult_shift_add_dp.sv | 96 +++++++++
 rtl/seq_multiplier.sv | 70 +++++++
 tb/tb_seq_multiplier.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
//   mult_state_e : controller states (idle, calculating, result held)
//   res_w()      : product width for a given operand width
//   cnt_w()      : bit-counter width for a given operand width
package mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mult_state_e;

  function automatic int unsigned res_w(input int unsigned w);
    return 2 * w;
  endfunction

  // The counter only has to hold WIDTH-1, so $clog2(WIDTH) bits are enough.
  // A floor of 1 bit keeps the vector legal.
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// Shift-add datapath for the sequential multiplier.
// It holds the operand magnitudes, the accumulator, the bit counter and the sign
// of the product. The registered result is the accumulator after the final
// conditional negate.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   load_i        : capture a_i/b_i/is_signed_i and start a new product
//   step_i        : process one multiplier bit
//   a_i, b_i      : multiplicand and multiplier
//   is_signed_i   : operands are two's complement
//   last_o        : the current step processes the final multiplier bit
//   result_o      : registered 2*WIDTH-bit product
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               is_signed_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int unsigned ResW = res_w(WIDTH);
  localparam int unsigned CntW = cnt_w(WIDTH);

  logic [ResW-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [ResW-1:0]  acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [ResW-1:0]  result_q, result_d;

  logic [WIDTH-1:0] mag_a, mag_b;
  logic [ResW-1:0]  acc_sum;

  // The most-negative value negates to itself.
  // Read as unsigned, that is exactly 2^(WIDTH-1).
  assign mag_a = (is_signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (is_signed_i && b_i[WIDTH-1]) ? -b_i : b_i;

  // The multiplicand shifts left and the multiplier shifts right.
  // The current multiplier bit is therefore always mplier_q[0].
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_o  = (cnt_q == '0);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (load_i) begin
      mcand_d  = {{WIDTH{1'b0}}, mag_a};
      mplier_d = mag_b;
      acc_d    = '0;
      cnt_d    = CntW'(WIDTH - 1);
      neg_d    = is_signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
    end else if (step_i) begin
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      acc_d    = acc_sum;
      cnt_d    = cnt_q - 1'b1;
      // Negating zero gives zero, so a zero product never comes out negative.
      if (last_o) begin
        result_d = neg_q ? -acc_sum : acc_sum;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

  assign result_o = result_q;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// It processes one multiplier bit per clock. The product appears exactly WIDTH
// cycles after the operands are accepted.
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid, in_ready  : operand handshake (a, b, is_signed)
//   a, b                : multiplicand and multiplier, WIDTH bits
//   is_signed           : 1 = two's complement operands, 0 = unsigned
//   out_valid,out_ready : result handshake
//   result              : 2*WIDTH-bit product, held after the handshake
//   busy                : an operation is in flight or its result is unconsumed
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  mult_state_e state_q, state_d;
  logic        load, step, last;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid)  state_d = StCalc;
      StCalc:  if (last)      state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign load      = in_ready && in_valid;
  assign step      = (state_q == StCalc);

  mult_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .load_i     (load),
    .step_i     (step),
    .a_i        (a),
    .b_i        (b),
    .is_signed_i(is_signed),
    .last_o     (last),
    .result_o   (result)
  );

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid3 = 1'b0, in_ready3, is_signed3 = 1'b0;
  logic        out_valid3, out_ready3 = 1'b1, busy3;
  logic [2:0]  a3 = '0, b3 = '0;
  logic [5:0]  res3;

  logic        in_valid8 = 1'b0, in_ready8, is_signed8 = 1'b0;
  logic        out_valid8, out_ready8 = 1'b1, busy8;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] res8;

  seq_multiplier #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3), .a(a3), .b(b3),
    .is_signed(is_signed3), .out_valid(out_valid3), .out_ready(out_ready3), .result(res3),
    .busy(busy3)
  );

  seq_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
    .is_signed(is_signed8), .out_valid(out_valid8), .out_ready(out_ready8), .result(res8),
    .busy(busy8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: interpret the operands as integers, multiply, keep 2*w bits.
  function automatic logic [31:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input bit s);
    longint av, bv, p;
    av = longint'(a) & ((longint'(1) << w) - 1);
    bv = longint'(b) & ((longint'(1) << w) - 1);
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    return 32'(p & ((longint'(1) << (2 * w)) - 1));
  endfunction

  function automatic logic [31:0] get_res(input int w);
    return (w == 3) ? 32'(res3) : 32'(res8);
  endfunction
  function automatic logic get_ov(input int w);
    return (w == 3) ? out_valid3 : out_valid8;
  endfunction
  function automatic logic get_ir(input int w);
    return (w == 3) ? in_ready3 : in_ready8;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 3) ? busy3 : busy8;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [15:0] a, input logic [15:0] b,
                        input logic s);
    if (w == 3) begin
      in_valid3 = v; a3 = a[2:0]; b3 = b[2:0]; is_signed3 = s;
    end else begin
      in_valid8 = v; a8 = a[7:0]; b8 = b[7:0]; is_signed8 = s;
    end
  endtask

  // Called #1 after a rising edge, with out_ready high. The task submits one
  // operation, measures the latency from acceptance to out_valid, checks that
  // out_valid lasts a single cycle, and returns the product.
  task automatic run_op(input int w, input logic [15:0] a, input logic [15:0] b, input bit s,
                        input string tag, output logic [31:0] res);
    int lat;
    check({tag, " in_ready before"}, 32'(get_ir(w)), 32'd1);
    set_in(w, 1'b1, a, b, s);
    @(posedge clk);
    #1;
    // The operands are scrambled after acceptance and must not matter.
    set_in(w, 1'b0, ~a, ~b, ~s);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (get_ov(w)) begin
        lat = c;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(w));
    res = get_res(w);
    @(posedge clk);
    #1;
    check({tag, " out_valid one cycle"}, 32'(get_ov(w)), 32'd0);
  endtask

  typedef struct {
    int          w;
    logic [15:0] a;
    logic [15:0] b;
    bit          s;
    logic [31:0] exp;
    string       name;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] r;
    int          seen;

    vecs.push_back('{3, 16'd7, 16'd7, 1'b0, 32'd49, "u7x7"});
    vecs.push_back('{3, 16'd5, 16'd3, 1'b0, 32'd15, "u5x3"});
    vecs.push_back('{3, 16'd4, 16'd4, 1'b1, 32'h10, "s-4x-4"});
    vecs.push_back('{3, 16'd7, 16'd3, 1'b1, 32'h3D, "s-1x3"});
    vecs.push_back('{3, 16'd3, 16'd4, 1'b1, 32'h34, "s3x-4"});
    vecs.push_back('{3, 16'd6, 16'd0, 1'b1, 32'h00, "s-2x0"});
    vecs.push_back('{8, 16'd255, 16'd255, 1'b0, 32'd65025, "u255x255"});
    vecs.push_back('{8, 16'd128, 16'd128, 1'b1, 32'd16384, "s-128x-128"});
    vecs.push_back('{8, 16'd127, 16'd128, 1'b1, 32'hC080, "s127x-128"});

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst out_valid", 32'(out_valid3), 32'd0);
    check("rst result", 32'(res3), 32'd0);
    check("rst busy", 32'(busy3), 32'd0);
    check("rst in_ready", 32'(in_ready3), 32'd1);
    check("rst result w8", 32'(res8), 32'd0);

    // Directed vectors
    foreach (vecs[i]) begin
      run_op(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].name, r);
      check({vecs[i].name, " result"}, r, vecs[i].exp);
    end

    // Backpressure: result is held and new operands are ignored until consumed
    out_ready3 = 1'b0;
    set_in(3, 1'b1, 16'd2, 16'd3, 1'b0);
    @(posedge clk);
    #1 set_in(3, 1'b1, 16'd1, 16'd1, 1'b0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1 if (out_valid3) seen = 1;
    end
    check("bp out_valid seen", 32'(seen), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("bp result held", 32'(res3), 32'd6);
      check("bp in_ready low", 32'(in_ready3), 32'd0);
      check("bp out_valid held", 32'(out_valid3), 32'd1);
    end
    out_ready3 = 1'b1;
    @(posedge clk);
    #1;
    check("bp in_ready after handshake", 32'(in_ready3), 32'd1);
    check("bp result kept", 32'(res3), 32'd6);
    @(posedge clk);
    #1;
    check("bp second accepted", 32'(busy3), 32'd1);
    set_in(3, 1'b0, 16'd0, 16'd0, 1'b0);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1 if (out_valid3) seen = 1;
    end
    check("bp second result", 32'(res3), 32'd1);
    @(posedge clk);
    #1;

    // Reset in the second calculation cycle discards the operation
    set_in(3, 1'b1, 16'd6, 16'd5, 1'b0);
    @(posedge clk);
    #1 set_in(3, 1'b0, 16'd0, 16'd0, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    check("mid rst busy", 32'(busy3), 32'd0);
    check("mid rst in_ready", 32'(in_ready3), 32'd1);
    check("mid rst result", 32'(res3), 32'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #1 if (out_valid3) seen = 1;
      @(posedge clk);
      #1 if (out_valid3) seen = 1;
    end
    check("mid rst no out_valid", 32'(seen), 32'd0);
    run_op(3, 16'd2, 16'd3, 1'b0, "after rst", r);
    check("after rst result", r, 32'd6);

    // Random operands checked against the integer model
    for (int i = 0; i < 40; i++) begin
      int          w;
      logic [15:0] ra, rb;
      bit          rs;
      w  = ($urandom_range(0, 1) == 0) ? 3 : 8;
      ra = 16'($urandom_range(0, (1 << w) - 1));
      rb = 16'($urandom_range(0, (1 << w) - 1));
      rs = 1'($urandom_range(0, 1));
      run_op(w, ra, rb, rs, "rand", r);
      check("rand result", r, model(w, ra, rb, rs));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
